// File: rtl/key_expand_ctrl_pkg.sv
// Shared types and constants for the AES-128 key-expansion controller:
// FSM state encoding, round count, watchdog limit and the round-constant table.
package key_expand_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_GAP,
    S_DONE
  } state_e;

  localparam logic [3:0]  NUM_ROUNDS = 4'd10;
  localparam int unsigned NUM_KEYS   = 11;
  localparam logic [7:0]  WD_LIMIT   = 8'd255;

  // Round constant for rounds 1..10; anything else maps to zero.
  function automatic logic [7:0] rcon_of(input logic [3:0] round);
    case (round)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/key_expand_ctrl_key_store.sv
// Round-key storage: 11 x 128-bit entries, one write port, one registered read
// port. Out-of-range read indices return zero; a same-cycle write is not bypassed.
module key_store
  import key_expand_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [3:0]   waddr,
  input  logic [127:0] wdata,
  input  logic [3:0]   raddr,
  output logic [127:0] rdata
);

  logic [127:0] mem_q [NUM_KEYS];
  logic [127:0] rdata_d, rdata_q;

  always_comb begin
    rdata_d = '0;
    if (raddr <= NUM_ROUNDS) rdata_d = mem_q[raddr];
  end

  // NOTE: the storage array has no reset; its contents are don't-care until
  // written, and leaving it unreset lets it map onto plain RAM/flop arrays.
  always_ff @(posedge clk) begin
    if (we && (waddr <= NUM_ROUNDS)) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/key_expand_ctrl.sv
// AES-128 key-expansion controller: sequences ten KeySchedule requests, stores
// the 11 round keys, and serves registered round-key reads.
module key_expand_ctrl
  import key_expand_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] cipher_key_i,
  output logic         ks_en_o,
  output logic [7:0]   ks_rcon_o,
  output logic [127:0] ks_key_o,
  input  logic         ks_key_flag_i,
  input  logic [127:0] ks_key_i,
  input  logic [3:0]   rd_round_i,
  output logic [127:0] rd_key_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         keys_valid_o,
  output logic         err_o
);

  state_e       state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   wd_q, wd_d;
  logic         keys_valid_q, keys_valid_d;
  logic         err_q, err_d;
  logic [127:0] prev_key_q, prev_key_d;

  logic         start_ok, capture, wd_expired;
  logic         we;
  logic [3:0]   waddr;
  logic [127:0] wdata;

  assign start_ok   = (state_q == S_IDLE) && start;
  assign capture    = (state_q == S_WAIT) && ks_key_flag_i;
  assign wd_expired = (state_q == S_WAIT) && !ks_key_flag_i && (wd_q == WD_LIMIT - 8'd1);

  // NOTE: state elements use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      round_q      <= '0;
      wd_q         <= '0;
      keys_valid_q <= 1'b0;
      err_q        <= 1'b0;
      prev_key_q   <= '0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      wd_q         <= wd_d;
      keys_valid_q <= keys_valid_d;
      err_q        <= err_d;
      prev_key_q   <= prev_key_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_REQ;
      S_REQ:  state_d = S_WAIT;
      S_WAIT: begin
        if (ks_key_flag_i)   state_d = S_GAP;
        else if (wd_expired) state_d = S_IDLE;
      end
      S_GAP:  state_d = (round_q < NUM_ROUNDS) ? S_REQ : S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // prev_key_q mirrors entry[round-1] so the request path needs no second read port.
  always_comb begin
    round_d      = round_q;
    wd_d         = wd_q;
    keys_valid_d = keys_valid_q;
    err_d        = wd_expired;
    prev_key_d   = prev_key_q;
    if (start_ok) begin
      round_d      = 4'd1;
      keys_valid_d = 1'b0;
      prev_key_d   = cipher_key_i;
    end
    if (state_q == S_REQ) wd_d = '0;
    if ((state_q == S_WAIT) && !ks_key_flag_i) wd_d = wd_expired ? 8'd0 : wd_q + 8'd1;
    if (capture) prev_key_d = ks_key_i;
    if ((state_q == S_GAP) && (round_q < NUM_ROUNDS)) round_d = round_q + 4'd1;
    if (state_q == S_DONE) keys_valid_d = 1'b1;
    if (wd_expired) keys_valid_d = 1'b0;
  end

  always_comb begin
    ks_en_o      = (state_q == S_REQ) || (state_q == S_WAIT);
    ks_rcon_o    = 8'h00;
    ks_key_o     = '0;
    if (ks_en_o) begin
      ks_rcon_o = rcon_of(round_q);
      ks_key_o  = prev_key_q;
    end
    busy_o       = (state_q != S_IDLE);
    done_o       = (state_q == S_DONE);
    keys_valid_o = keys_valid_q;
    err_o        = err_q;
  end

  assign we    = start_ok || capture;
  assign waddr = start_ok ? 4'd0 : round_q;
  assign wdata = start_ok ? cipher_key_i : ks_key_i;

  key_store u_key_store (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rd_round_i),
    .rdata (rd_key_o)
  );

endmodule

// File: tb/tb_key_expand_ctrl.sv
// Scoreboard bench for key_expand_ctrl with a behavioural AES-128 KeySchedule
// peer; stimulus pushes expectations, monitors pop and compare.
module tb_key_expand_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] cipher_key_i = '0;
  logic         ks_en_o;
  logic [7:0]   ks_rcon_o;
  logic [127:0] ks_key_o;
  logic         ks_key_flag_i = 1'b0;
  logic [127:0] ks_key_i = '0;
  logic [3:0]   rd_round_i = '0;
  logic [127:0] rd_key_o;
  logic         busy_o, done_o, keys_valid_o, err_o;

  key_expand_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cipher_key_i  (cipher_key_i),
    .ks_en_o       (ks_en_o),
    .ks_rcon_o     (ks_rcon_o),
    .ks_key_o      (ks_key_o),
    .ks_key_flag_i (ks_key_flag_i),
    .ks_key_i      (ks_key_i),
    .rd_round_i    (rd_round_i),
    .rd_key_o      (rd_key_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .keys_valid_o  (keys_valid_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic flag_unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // ---------------- AES-128 key schedule model ----------------
  logic [7:0] rcon_tb [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                               8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t = {x, x};
    return t[15-n -: 8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  // Byte 4r+c of the bus is row r of word c; row 0 is the word's MSB.
  function automatic logic [31:0] get_word(input logic [127:0] k, input int c);
    logic [31:0] w;
    for (int r = 0; r < 4; r++) w[31-8*r -: 8] = k[8*(4*r+c) +: 8];
    return w;
  endfunction

  function automatic logic [127:0] pack_words(input logic [31:0] w0, w1, w2, w3);
    logic [31:0]  w [4];
    logic [127:0] k;
    w = '{w0, w1, w2, w3};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) k[8*(4*r+c) +: 8] = w[c][31-8*r -: 8];
    return k;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = get_word(k, 0); w1 = get_word(k, 1); w2 = get_word(k, 2); w3 = get_word(k, 3);
    t  = {w3[23:0], w3[31:24]};
    t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
    w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return pack_words(w0, w1, w2, w3);
  endfunction

  // KeySchedule peer: answers each new request after a short variable delay.
  bit stub_dead = 1'b0;
  initial begin : ks_peer
    bit           pending = 1'b0;
    bit           en_prev = 1'b0;
    int           cnt = 0;
    logic [127:0] nk = '0;
    forever begin
      @(negedge clk);
      ks_key_flag_i = 1'b0;
      if (rst) begin
        pending = 1'b0;
      end else if (ks_en_o && !en_prev && !stub_dead) begin
        pending = 1'b1;
        cnt     = int'($urandom_range(0, 3));
        nk      = next_key(ks_key_o, ks_rcon_o);
      end else if (pending) begin
        if (cnt == 0) begin
          ks_key_i      = nk;
          ks_key_flag_i = 1'b1;
          pending       = 1'b0;
        end else begin
          cnt--;
        end
      end
      en_prev = ks_en_o;
    end
  end

  // ---------------- scoreboard queues ----------------
  typedef struct {
    logic [7:0]   rcon;
    logic [127:0] key;
  } req_t;

  typedef struct {
    string        name;
    logic [127:0] exp;
    logic [127:0] mask;
  } rd_t;

  typedef enum int {EV_DONE, EV_ERR} ev_e;

  req_t req_q [$];
  rd_t  rd_q  [$];
  ev_e  ev_q  [$];

  logic [127:0] mk [11];
  logic [127:0] ka [11];
  bit rd_fire = 1'b0;
  bit rd_fire_d = 1'b0;

  always @(posedge clk) rd_fire_d <= rd_fire;

  // Request monitor: rcon/key on each REQ and exactly one idle cycle between rounds.
  initial begin : req_mon
    bit en_prev = 1'b0;
    bit gap_arm = 1'b0;
    int gap_cnt = 0;
    req_t e;
    forever begin
      @(negedge clk);
      if (!busy_o) gap_arm = 1'b0;
      if (ks_en_o && !en_prev) begin
        if (req_q.size() == 0) flag_unexpected("req_unexpected");
        else begin
          e = req_q.pop_front();
          check($sformatf("req_rcon_%h", e.rcon), ks_rcon_o, e.rcon);
          check($sformatf("req_key_%h", e.rcon), ks_key_o, e.key);
        end
        if (gap_arm) check("gap_len", gap_cnt, 1);
      end
      if (!ks_en_o && en_prev && busy_o) begin
        gap_arm = 1'b1;
        gap_cnt = 0;
      end
      if (!ks_en_o && gap_arm) gap_cnt++;
      en_prev = ks_en_o;
    end
  end

  initial begin : rd_mon
    rd_t e;
    forever begin
      @(negedge clk);
      if (rd_fire_d) begin
        if (rd_q.size() == 0) flag_unexpected("rd_unexpected");
        else begin
          e = rd_q.pop_front();
          check(e.name, rd_key_o & e.mask, e.exp);
        end
      end
    end
  end

  initial begin : ev_mon
    ev_e e;
    forever begin
      @(negedge clk);
      if (done_o) begin
        if (ev_q.size() == 0) flag_unexpected("done_unexpected");
        else begin
          e = ev_q.pop_front();
          check("ev_done_kind", e, EV_DONE);
        end
      end
      if (err_o) begin
        if (ev_q.size() == 0) flag_unexpected("err_unexpected");
        else begin
          e = ev_q.pop_front();
          check("ev_err_kind", e, EV_ERR);
          check("err_busy", busy_o, 1'b0);
          check("err_keys_valid", keys_valid_o, 1'b0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [127:0] ALL = '1;
  localparam logic [127:0] M32 = 128'hffff_ffff;

  task automatic push_run(input logic [127:0] k, input int nrounds, input bit with_done);
    mk[0] = k;
    for (int i = 1; i <= 10; i++) mk[i] = next_key(mk[i-1], rcon_tb[i]);
    for (int i = 1; i <= nrounds; i++) req_q.push_back(req_t'{rcon: rcon_tb[i], key: mk[i-1]});
    if (with_done) ev_q.push_back(EV_DONE);
  endtask

  task automatic start_pulse(input logic [127:0] k);
    cipher_key_i = k;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic rd_issue(input string name, input logic [3:0] idx,
                          input logic [127:0] exp, input logic [127:0] mask);
    rd_round_i = idx;
    rd_fire = 1'b1;
    rd_q.push_back(rd_t'{name: name, exp: exp, mask: mask});
    @(negedge clk);
  endtask

  task automatic rd_stop();
    rd_fire = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (busy_o && n < max) begin
      @(negedge clk);
      n++;
    end
    check(name, busy_o, 1'b0);
  endtask

  task automatic wait_round(input string name, input logic [7:0] rc, input bit need_flag);
    int n = 0;
    while (!(ks_en_o && ks_rcon_o == rc && (ks_key_flag_i || !need_flag)) && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, ks_rcon_o, rc);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ks_en"}, ks_en_o, 1'b0);
    check({tag, "_ks_rcon"}, ks_rcon_o, 8'h00);
    check({tag, "_ks_key"}, ks_key_o, '0);
    check({tag, "_rd_key"}, rd_key_o, '0);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_done"}, done_o, 1'b0);
    check({tag, "_keys_valid"}, keys_valid_o, 1'b0);
    check({tag, "_err"}, err_o, 1'b0);
  endtask

  initial begin : stim
    logic [127:0] key_a, key_b, key_c, key_d;
    int n, n_en;
    key_a = pack_words(32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c);
    key_b = pack_words(32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f);
    key_c = pack_words(32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'hcafef00d);
    key_d = pack_words(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Run A: FIPS-197 key, with a start pulse in round 4 that must be ignored.
    push_run(key_a, 10, 1'b1);
    for (int i = 0; i < 11; i++) ka[i] = mk[i];
    start_pulse(key_a);
    wait_round("run_a_round4", 8'h08, 1'b0);
    start_pulse(key_b);
    wait_idle("run_a_finish", 1000);
    check("run_a_keys_valid", keys_valid_o, 1'b1);
    for (int i = 0; i < 11; i++) rd_issue($sformatf("rd_a_%0d", i), 4'(i), ka[i], ALL);
    rd_issue("rd_fips_r1_bytes", 4'd1, 128'h2a2388a0, M32);
    rd_issue("rd_fips_r10_bytes", 4'd10, 128'hb6e1c9d0, M32);
    rd_issue("rd_idx11", 4'd11, '0, ALL);
    rd_issue("rd_idx15", 4'd15, '0, ALL);
    rd_stop();

    // Run B: restart from IDLE with valid keys; read entry 1 as it is captured.
    push_run(key_b, 10, 1'b1);
    start_pulse(key_b);
    check("run_b_kv_cleared", keys_valid_o, 1'b0);
    wait_round("run_b_capture_r1", 8'h01, 1'b1);
    rd_issue("rd_collide_old", 4'd1, ka[1], ALL);
    rd_issue("rd_collide_new", 4'd1, mk[1], ALL);
    rd_stop();
    wait_idle("run_b_finish", 1000);
    check("run_b_keys_valid", keys_valid_o, 1'b1);

    // Run C: start in the IDLE cycle right after DONE.
    push_run(key_c, 10, 1'b1);
    start_pulse(key_c);
    check("run_c_kv_dropped", keys_valid_o, 1'b0);
    wait_idle("run_c_finish", 1000);
    check("run_c_keys_valid", keys_valid_o, 1'b1);
    rd_issue("rd_c_0", 4'd0, mk[0], ALL);
    rd_issue("rd_c_5", 4'd5, mk[5], ALL);
    rd_issue("rd_c_10", 4'd10, mk[10], ALL);
    rd_stop();

    // Run D: KeySchedule never answers, so the watchdog fires.
    stub_dead = 1'b1;
    req_q.push_back(req_t'{rcon: 8'h01, key: key_d});
    ev_q.push_back(EV_ERR);
    start_pulse(key_d);
    n = 0;
    n_en = 0;
    while (busy_o && n < 1000) begin
      if (ks_en_o) n_en++;
      @(negedge clk);
      n++;
    end
    check("wd_finish", busy_o, 1'b0);
    check("wd_en_cycles", n_en, 256);
    check("wd_err_pulse", err_o, 1'b1);
    @(negedge clk);
    check("wd_err_one_cycle", err_o, 1'b0);
    stub_dead = 1'b0;
    repeat (8) @(negedge clk);

    // Run E: reset during round 6 aborts with no done pulse.
    push_run(key_a, 6, 1'b0);
    start_pulse(key_a);
    wait_round("run_e_round6", 8'h20, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("abort");
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_req_drained", req_q.size(), 0);
    check("ev_queue_drained", ev_q.size(), 0);
    check("abort_idle", busy_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_expand_ctrl.md
KEY_EXPAND_CTRL -- requirements
Module: key_expand_ctrl

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high; one clock domain only.
REQ-003 SHALL have port start  input  1  one-cycle pulse that begins expansion of cipher_key_i.
REQ-004 SHALL have port cipher_key_i  input  128  AES-128 cipher key; byte 4*r+c at bits [8(4r+c)+7 : 8(4r+c)] is row r, word c.
REQ-005 SHALL have port ks_en_o  output  1  enable to the KeySchedule stage.
REQ-006 SHALL have port ks_rcon_o  output  8  round constant to the KeySchedule stage.
REQ-007 SHALL have port ks_key_o  output  128  previous round key to the KeySchedule stage.
REQ-008 SHALL have port ks_key_flag_i  input  1  KeySchedule result-valid flag.
REQ-009 SHALL have port ks_key_i  input  128  next round key from the KeySchedule stage.
REQ-010 SHALL have port rd_round_i  input  4  round-key read index, 0..10.
REQ-011 SHALL have port rd_key_o  output  128  registered round key for rd_round_i.
REQ-012 SHALL have ports busy_o, done_o, keys_valid_o, err_o  output  1 each  status.

Function
REQ-013 SHALL store 11 round keys; entry 0 is cipher_key_i, captured in the cycle start is sampled in IDLE.
REQ-014 SHALL use FSM states IDLE -> REQ -> WAIT -> GAP -> REQ ... -> DONE -> IDLE.
REQ-015 In REQ (one cycle) SHALL drive ks_key_o = entry[round-1] and ks_rcon_o = RCON[round], round counting 1..10, then enter WAIT.
REQ-016 SHALL hold ks_en_o=1 in REQ and WAIT, with ks_key_o and ks_rcon_o stable until capture.
REQ-017 In WAIT, on ks_key_flag_i=1, SHALL write ks_key_i into entry[round] and enter GAP; flag outside WAIT is ignored.
REQ-018 In GAP SHALL drive ks_en_o=0 for exactly one cycle; then go to REQ if round<10, else DONE.
REQ-019 RCON sequence SHALL be 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10; ks_rcon_o=00 outside REQ/WAIT.
REQ-020 DONE SHALL last one cycle: done_o=1 pulse, keys_valid_o set to 1, return to IDLE.
REQ-021 busy_o SHALL be 1 in every state except IDLE.
REQ-022 start while busy_o=1 SHALL be ignored; start in IDLE with keys_valid_o=1 SHALL clear keys_valid_o and restart.
REQ-023 A watchdog SHALL count WAIT cycles; at 255 with no flag it SHALL pulse err_o one cycle, clear keys_valid_o, and go to IDLE.
REQ-024 rd_key_o SHALL update one cycle after rd_round_i (1-cycle read latency); index >10 SHALL return all zeros.
REQ-025 A capture and a read of the same entry in the same cycle SHALL return the old value.

Reset
REQ-026 On rst=1 at a clock edge: FSM=IDLE, round=0, watchdog=0.
REQ-027 On rst=1 at a clock edge: ks_en_o=0, ks_rcon_o=00, ks_key_o=0, rd_key_o=0.
REQ-028 On rst=1 at a clock edge: busy_o, done_o, keys_valid_o and err_o all 0.
REQ-029 Key storage contents SHALL be don't-care after reset; reset mid-expansion SHALL abort with no done_o pulse.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, the RCON table, and constants NUM_ROUNDS=10 and WD_LIMIT=255.
REQ-031 One sub-module, key_store (11x128 storage, one write port, one registered read port), is natural; the FSM and counters stay in the top level.

Verification
REQ-032 Bench SHALL instantiate the real KeySchedule; start with FIPS-197 key 2b7e1516 28aed2a6 abf71588 09cf4f3c -> done_o pulses once.
REQ-033 After that run, rd_round_i=1 SHALL give bytes 0..3 = a0,88,23,2a; rd_round_i=10 SHALL give bytes 0..3 = d0,c9,e1,b6.
REQ-034 Observed ks_rcon_o per REQ cycle SHALL equal 01..36 in order, with exactly one ks_en_o=0 cycle between rounds.
REQ-035 Stub that never raises ks_key_flag_i -> err_o pulses after 255 WAIT cycles, busy_o=0, keys_valid_o=0.
REQ-036 start pulses during round 4 -> ignored, results unchanged; rst asserted in round 6 -> all outputs 0 next cycle, no done_o.
REQ-037 rd_round_i=11 and 15 -> rd_key_o=0; back-to-back start after DONE -> keys_valid_o drops, then reasserts with new keys.
